// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit-to-16-bit SRAM bridge.
package sram_controller_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_LO = 3'd1,
        ACC_HI = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Settle-time down-counter: loaded when leaving ACC_HI, decremented in WAIT.
module wait_counter
    import sram_controller_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = (cnt == CW'(1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM cycles plus settle time,
// holding ready low so the pipeline freezes until the access completes.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        st_val,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t        state, next_state;
    logic          wr_q;
    logic [31:0]   addr_q, st_q, eff;
    logic [CW-1:0] wait_cnt;
    logic          wait_last;
    logic          req;
    logic          unused_eff_bits;

    assign req = wr_en | rd_en;
    assign eff = addr_q - BASE_ADDR;
    // Bits outside the 512 KiB SRAM window are dropped.
    assign unused_eff_bits = ^{eff[31:19], eff[1:0], wait_cnt};

    wait_counter #(.CW(CW)) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ACC_HI),
        .dec      (state == WAIT),
        .load_val (CW'(WAIT_CYCLES)),
        .cnt      (wait_cnt),
        .last     (wait_last)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                if (req) next_state = ACC_LO;
                else     ready      = 1'b1;
            end
            ACC_LO: begin
                next_state = ACC_HI;
                sram_addr  = {eff[18:2], 1'b0};
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = st_q[15:0];
                end
            end
            ACC_HI: begin
                next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
                sram_addr  = {eff[18:2], 1'b1};
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = st_q[31:16];
                end
            end
            WAIT: begin
                if (wait_last) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
                ready      = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request is latched once on acceptance; write wins when both enables are set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q    <= '0;
            st_q      <= '0;
            wr_q      <= 1'b0;
            read_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                addr_q <= address;
                st_q   <= st_val;
                wr_q   <= wr_en;
            end
            if (state == ACC_LO && !wr_q) read_data[15:0]  <= sram_dq_in;
            if (state == ACC_HI && !wr_q) read_data[31:16] <= sram_dq_in;
        end
    end

endmodule
